// File: rtl/instr_output_monitor.sv
`default_nettype none
// ============================================================================
// Module   : instr_output_monitor
// Brief    : Sink-side instrumentation for an AXI-Stream output. Accepts
//            beats, counts them, measures first-input to first-output
//            latency, the interval between frame ends, and a per-frame
//            checksum of {frame_idx[7:0], sum[23:0]}.
// Options  : INSTR_BACKPRESSURE_EN - when defined, s_axis_tready is pulled
//            low one cycle in four (free 2-bit counter == 3) to throttle
//            the upstream design to 3-of-4 throughput.
// Revision : 1.0 - initial release
// ============================================================================
module instr_output_monitor #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_BEATS = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  enable,
  input  logic                  in_first_beat,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [CNT_WIDTH-1:0]  status_o,
  output logic [CNT_WIDTH-1:0]  latency,
  output logic [CNT_WIDTH-1:0]  interval,
  output logic [31:0]           checksum,
  output logic                  frame_done
);

  // Beat index is sized for the largest legal frame (65535 beats).
  localparam int              IDX_WIDTH = 16;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   ready;
  logic                   accept;
  logic                   capture;
  logic                   is_last;
  logic                   frame_end;
  logic [IDX_WIDTH-1:0]   beat_idx;
  logic [23:0]            sum;
  logic [23:0]            addend;
  logic [23:0]            sum_next;
  logic [7:0]             frame_idx;
  logic [CNT_WIDTH-1:0]   wait_cnt;
  logic [CNT_WIDTH-1:0]   iv_cnt;
  logic                   iv_running;

  // Only the low 24 data bits feed the checksum; the rest are deliberately dropped.
  if (DATA_WIDTH > 24) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^s_axis_tdata[DATA_WIDTH-1:24];
  end

`ifdef INSTR_BACKPRESSURE_EN
  logic [1:0] bp_cnt;

  // Free-running throttle phase; advances on every enabled cycle.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      bp_cnt <= 2'd0;
    end else if (enable) begin
      bp_cnt <= bp_cnt + 2'd1;
    end
  end

  assign ready = ap_rst_n & enable & (bp_cnt != 2'd3);
`else
  assign ready = ap_rst_n & enable;
`endif

  assign s_axis_tready = ready;
  assign accept        = s_axis_tvalid & ready;
  assign is_last       = (beat_idx == LAST_IDX);
  assign frame_end     = accept & is_last;
  assign addend        = s_axis_tdata[23:0] ^ {{(24 - IDX_WIDTH){1'b0}}, beat_idx};
  assign sum_next      = sum + addend;

  // FSM state register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; capture marks the one cycle that latches latency.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (in_first_beat && enable) begin
          if (accept) begin
            state_next = RUN;
            capture    = 1'b1;
          end else begin
            state_next = WAIT_FIRST;
          end
        end
      end
      WAIT_FIRST: begin
        if (accept) begin
          state_next = RUN;
          capture    = 1'b1;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latency counter: zero while idle, counts up (saturating) while waiting.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if ((state == WAIT_FIRST) && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_ONE;
    end
  end

  // Latency is captured once; a same-cycle first beat reads as zero.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      latency <= '0;
    end else if (capture) begin
      latency <= (state == IDLE) ? '0 : wait_cnt;
    end
  end

  // Beat bookkeeping, running sum and checksum registration at frame end.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      status_o   <= '0;
      beat_idx   <= '0;
      sum        <= '0;
      frame_idx  <= '0;
      checksum   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (accept) begin
        if (status_o != CNT_MAX) begin
          status_o <= status_o + CNT_ONE;
        end
        if (is_last) begin
          beat_idx  <= '0;
          sum       <= '0;
          checksum  <= {frame_idx, sum_next};
          frame_idx <= frame_idx + 8'd1;
        end else begin
          beat_idx  <= beat_idx + IDX_WIDTH'(1);
          sum       <= sum_next;
        end
      end
    end
  end

  // Frame-to-frame interval: the counter starts at the first frame end.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      iv_running <= 1'b0;
      iv_cnt     <= '0;
      interval   <= '0;
    end else if (frame_end) begin
      if (iv_running) begin
        interval <= iv_cnt;
      end
      iv_running <= 1'b1;
      iv_cnt     <= CNT_ONE;
    end else if (iv_running && (iv_cnt != CNT_MAX)) begin
      iv_cnt <= iv_cnt + CNT_ONE;
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_output_monitor.md
INSTR_OUTPUT_MONITOR -- requirements
Module: instr_output_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output stream data width in bits, minimum 24.
REQ-002 SHALL have parameter FRAME_BEATS, default 16, beats per output frame, range 2..65535.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of latency/interval/beat counters.
REQ-004 SHALL have ports, in this order:
 - ap_clk  in  1  sole clock, all logic on rising edge.
 - ap_rst_n  in  1  reset, synchronous and active-low.
 - enable  in  1  sink start bit from control register bit 1.
 - in_first_beat  in  1  one-cycle pulse when the input generator emits beat 0 of any frame.
 - s_axis_tdata  in  DATA_WIDTH  output stream data from the design under test.
 - s_axis_tvalid  in  1  stream valid.
 - s_axis_tready  out  1  stream ready.
 - status_o  out  CNT_WIDTH  total accepted output beats.
 - latency  out  CNT_WIDTH  first-input-beat to first-output-beat cycles.
 - interval  out  CNT_WIDTH  cycles between last two frame-end beats.
 - checksum  out  32  {frame_idx[7:0], sum[23:0]} of the last completed frame.
 - frame_done  out  1  one-cycle pulse on each frame-end beat.

Function
REQ-005 SHALL accept a beat when s_axis_tvalid and s_axis_tready are both 1 on a rising edge.
REQ-006 SHALL drive s_axis_tready = 1 whenever enable = 1, except as modified by REQ-020; 0 when enable = 0.
REQ-007 SHALL implement FSM IDLE -> WAIT_FIRST (on in_first_beat while enable) -> RUN (on first accepted beat); RUN is held until reset.
REQ-008 SHALL accept and count beats in IDLE and WAIT_FIRST as well; only latency capture depends on FSM state.
REQ-009 SHALL, in WAIT_FIRST, count cycles starting from 0 in the cycle after in_first_beat; latency gets the count on the first accepted beat, captured exactly once.
REQ-010 SHALL produce latency = 0 when in_first_beat and the first accepted beat share a cycle; that transition goes IDLE -> RUN directly.
REQ-011 SHALL track beat index 0..FRAME_BEATS-1, incrementing per accepted beat and wrapping to 0 after FRAME_BEATS-1.
REQ-012 SHALL add (tdata[23:0] XOR beat_index[23:0]) modulo 2^24 into the accumulator per accepted beat, restarting from 0 at beat index 0.
REQ-013 SHALL, on the accepted beat with index FRAME_BEATS-1, register checksum = {frame_idx, final sum} and pulse frame_done the next cycle; checksum is valid the cycle after that beat.
REQ-014 SHALL start frame_idx at 0, increment it after each frame end, and wrap 255 -> 0.
REQ-015 SHALL run a free counter from the first frame end; on each later frame end, interval gets the count and the counter restarts at 1.
REQ-016 SHALL saturate latency, interval and status_o counters at all-ones (no wrap).
REQ-017 SHALL, when enable drops mid-frame, hold beat index, sum and FSM state, and resume on re-enable.
REQ-018 SHALL ignore in_first_beat outside IDLE.

Reset
REQ-019 SHALL, on ap_rst_n = 0 at a rising edge, set FSM to IDLE and set s_axis_tready, status_o, latency, interval, checksum, frame_done, beat index, sum and frame_idx to 0; reset mid-frame discards the partial frame.

Configuration
REQ-020 SHALL, when INSTR_BACKPRESSURE_EN is defined, force s_axis_tready low in every cycle where a free 2-bit cycle counter (reset 0, counts whenever enable = 1) equals 3, giving 3-of-4 throttling; when it is not defined, s_axis_tready follows REQ-006 exactly with no added logic.

Verification
REQ-021 SHALL check this case with FRAME_BEATS=4, macro off: tdata=1 on 4 consecutive beats -> checksum 0x00000006 and one frame_done pulse; a second identical frame -> 0x01000006.
REQ-022 SHALL check this case: in_first_beat at cycle 100, first beat accepted at cycle 137 -> latency 36; a later in_first_beat does not change latency.
REQ-023 SHALL check this case: frame ends at cycles 200 and 264 -> interval 64.
REQ-024 SHALL check this case: enable dropped after beat 2 for 10 cycles -> tready 0 during the gap, then frame completes with the same checksum as an unbroken frame.
REQ-025 SHALL check this case with the macro on: tvalid held high for 40 cycles -> status_o 30, and tready low exactly on every 4th cycle.
REQ-026 SHALL check this case: reset asserted after beat 1 of a frame -> all outputs 0; the next full frame with tdata=1 gives checksum 0x00000006.
